// File: rtl/fpu_divide_seq.sv
// fpu_divide_seq: multi-cycle restoring divider for FP32 significands.
// Produces floor((a<<27)/b) as a 51-bit quotient, with the sticky bit OR'd into bit 0.
// The sideband (sign, exponent, round mode) passes through untouched.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for operands; in_ready=1
// S_DIVIDE | retiring BITS_PER_CYCLE quotient bits per cycle, MSB first
// S_DONE   | result valid; held until out_ready
`timescale 1ns/1ps
module fpu_divide_seq #(
   parameter int BITS_PER_CYCLE = 1,
   parameter int USER_WIDTH     = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [23:0]           in_a,
   input  logic [23:0]           in_b,
   input  logic [USER_WIDTH-1:0] in_user,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [50:0]           out_quotient,
   output logic                  out_div_zero,
   output logic [USER_WIDTH-1:0] out_user
);

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

   localparam logic [5:0] COUNT_END = 6'd51;

   state_t                  state_q, state_nxt;
   logic [71:0]             rem_q;
   logic [23:0]             divisor_q;
   logic [50:0]             quot_q;
   logic [5:0]              count_q;
   logic                    div_zero_q;
   logic [USER_WIDTH-1:0]   user_q;

   logic [71:0]             rem_nxt;
   logic [71:0]             step_x;
   logic [6:0]              step_idx;
   logic [6:0]              step_sh;
   logic [BITS_PER_CYCLE-1:0] step_bits;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_nxt;
   end

   // Next-state logic; a zero divisor skips straight to DONE after one cycle.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:   if (in_valid) state_nxt = S_DIVIDE;
         S_DIVIDE: if (div_zero_q || count_q == COUNT_END) state_nxt = S_DONE;
         S_DONE:   if (out_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   // One cycle's worth of compare/subtract steps. The last three quotient bits
   // come from the remainder shifted up by 3, so the divisor shift restarts at 2.
   always_comb begin
      rem_nxt   = rem_q;
      step_x    = '0;
      step_idx  = '0;
      step_sh   = '0;
      step_bits = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         step_idx = {1'b0, count_q} + 7'(k);
         if (step_idx == 7'd48) rem_nxt = rem_nxt << 3;
         step_sh = (step_idx < 7'd48) ? (7'd47 - step_idx) : (7'd50 - step_idx);
         step_x  = {48'b0, divisor_q} << step_sh;
         if (step_x <= rem_nxt) begin
            rem_nxt = rem_nxt - step_x;
            step_bits[BITS_PER_CYCLE-1-k] = 1'b1;
         end
      end
   end

   // Datapath: capture operands, iterate, fold in sticky on the way to DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q      <= '0;
         divisor_q  <= '0;
         quot_q     <= '0;
         count_q    <= '0;
         div_zero_q <= 1'b0;
         user_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  rem_q      <= {24'b0, in_a, 24'b0};
                  divisor_q  <= in_b;
                  user_q     <= in_user;
                  quot_q     <= '0;
                  count_q    <= '0;
                  div_zero_q <= (in_b == 24'd0);
               end
            end
            S_DIVIDE: begin
               if (div_zero_q) begin
                  quot_q <= '1;
               end else if (count_q == COUNT_END) begin
                  quot_q[0] <= quot_q[0] | (|rem_q);
               end else begin
                  rem_q   <= rem_nxt;
                  quot_q  <= {quot_q[50-BITS_PER_CYCLE:0], step_bits};
                  count_q <= count_q + 6'(BITS_PER_CYCLE);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_quotient = quot_q;
   assign out_div_zero = div_zero_q;
   assign out_user     = user_q;

endmodule

// File: tb/tb_fpu_divide_seq.sv
// Bench for fpu_divide_seq: both BITS_PER_CYCLE builds side by side, directed
// cases plus random operands against an arithmetic reference.
`timescale 1ns/1ps
module tb_fpu_divide_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] in_a, in_b;
   logic [10:0] in_user;
   logic        out_ready;

   logic        in_ready_b1, out_valid_b1, div_zero_b1;
   logic [50:0] quot_b1;
   logic [10:0] user_b1;
   logic        in_ready_b3, out_valid_b3, div_zero_b3;
   logic [50:0] quot_b3;
   logic [10:0] user_b3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fpu_divide_seq #(.BITS_PER_CYCLE(1), .USER_WIDTH(11)) u_div_b1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b1),
      .in_a(in_a), .in_b(in_b), .in_user(in_user),
      .out_valid(out_valid_b1), .out_ready(out_ready),
      .out_quotient(quot_b1), .out_div_zero(div_zero_b1), .out_user(user_b1)
   );

   fpu_divide_seq #(.BITS_PER_CYCLE(3), .USER_WIDTH(11)) u_div_b3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b3),
      .in_a(in_a), .in_b(in_b), .in_user(in_user),
      .out_valid(out_valid_b3), .out_ready(out_ready),
      .out_quotient(quot_b3), .out_div_zero(div_zero_b3), .out_user(user_b3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [50:0] model_q(input logic [23:0] a, input logic [23:0] b);
      logic [63:0] num, q, r;
      if (b == 24'd0) return '1;
      num = {40'b0, a} << 27;
      q = num / {40'b0, b};
      r = num % {40'b0, b};
      return q[50:0] | 51'(r != 0);
   endfunction

   task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [10:0] u,
                         input logic [50:0] exp_q, input bit stall);
      int          lat1, lat3;
      bit          g1, g3, exp_dz, idle;
      logic [50:0] q1, q3;
      logic [10:0] u1, u3;
      exp_dz = (b == 24'd0);
      lat1 = 0; lat3 = 0; g1 = 0; g3 = 0; q1 = '0; q3 = '0; u1 = '0; u3 = '0;
      out_ready = !stall;
      in_a = a; in_b = b; in_user = u; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 24'($urandom); in_b = 24'($urandom); in_user = 11'($urandom);
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (!g1 && out_valid_b1) begin
            g1 = 1; lat1 = n; q1 = quot_b1; u1 = user_b1;
            check("quot_b1", quot_b1, exp_q);
            check("dz_b1", div_zero_b1, exp_dz);
            check("user_b1", user_b1, u);
         end
         if (!g3 && out_valid_b3) begin
            g3 = 1; lat3 = n; q3 = quot_b3; u3 = user_b3;
            check("quot_b3", quot_b3, exp_q);
            check("dz_b3", div_zero_b3, exp_dz);
            check("user_b3", user_b3, u);
         end
         if (g1 && g3) break;
      end
      check("done_b1", g1, 1);
      check("done_b3", g3, 1);
      check("lat_b1", lat1, exp_dz ? 1 : 52);
      check("lat_b3", lat3, exp_dz ? 1 : 18);
      if (stall && g1 && g3) begin
         for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("stall_valid_b1", out_valid_b1, 1);
            check("stall_ready_b1", in_ready_b1, 0);
            check("stall_quot_b1", quot_b1, q1);
            check("stall_user_b1", user_b1, u1);
            check("stall_valid_b3", out_valid_b3, 1);
            check("stall_ready_b3", in_ready_b3, 0);
            check("stall_quot_b3", quot_b3, q3);
            check("stall_user_b3", user_b3, u3);
         end
         out_ready = 1'b1;
      end
      idle = 0;
      for (int n = 0; n < 10; n++) begin
         if (in_ready_b1 && in_ready_b3) begin
            idle = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("back_idle", idle, 1);
   endtask

   initial begin
      logic [23:0] ra, rb;
      logic [10:0] ru;
      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_user = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready_b1", in_ready_b1, 1);
      check("rst_out_valid_b1", out_valid_b1, 0);
      check("rst_quot_b1", quot_b1, 0);
      check("rst_dz_b1", div_zero_b1, 0);
      check("rst_user_b1", user_b1, 0);
      check("rst_in_ready_b3", in_ready_b3, 1);
      check("rst_out_valid_b3", out_valid_b3, 0);
      check("rst_quot_b3", quot_b3, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_op(24'h800000, 24'h800000, 11'h155, 51'h0000008000000, 0);
      run_op(24'hC00000, 24'h800000, 11'h2AA, 51'h000000C000000, 0);
      run_op(24'h800000, 24'hC00000, 11'h0F0, 51'h0000005555555, 0);
      run_op(24'h9ABCDE, 24'h000000, 11'h7FF, {51{1'b1}}, 0);
      run_op(24'hFFFFFF, 24'h800001, 11'h123, model_q(24'hFFFFFF, 24'h800001), 1);
      run_op(24'h000000, 24'h000000, 11'h001, {51{1'b1}}, 1);

      // reset while both builds are mid-divide
      in_a = 24'h800000; in_b = 24'hC00000; in_user = 11'h3C3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid_b1", out_valid_b1, 0);
      check("mid_rst_ready_b1", in_ready_b1, 1);
      check("mid_rst_quot_b1", quot_b1, 0);
      check("mid_rst_valid_b3", out_valid_b3, 0);
      check("mid_rst_ready_b3", in_ready_b3, 1);
      check("mid_rst_user_b3", user_b3, 0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      run_op(24'h800000, 24'hC00000, 11'h0AB, 51'h0000005555555, 0);
      run_op(24'hFFFFFF, 24'h000001, 11'h111, model_q(24'hFFFFFF, 24'h000001), 0);

      for (int i = 0; i < 300; i++) begin
         ra = 24'($urandom);
         rb = 24'($urandom);
         ru = 11'($urandom);
         case ($urandom_range(0, 5))
            0: begin ra = ra | 24'h800000; rb = rb | 24'h800000; end
            1: ;
            2: rb = 24'd0;
            3: ra = 24'd0;
            4: rb = 24'($urandom_range(1, 7));
            default: rb = ra | 24'h000001;
         endcase
         run_op(ra, rb, ru, model_q(ra, rb), ($urandom_range(0, 15) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
